imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, parametrised immediate generator for the decode stage of the RV32IM pipeline. It extracts and sign-extends the immediate of every base instruction format to XLEN bits, selected by the control unit's IMM_PICK code. It also precomputes PC + immediate for branch, jump and AUIPC targets. A two-entry skid buffer with a valid/ready handshake lets a downstream stall propagate without losing an instruction, and a FLUSH input discards in-flight entries on a taken branch.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  upstream has a valid instruction.
- IN_READY  out  1  stage can accept a new instruction.
- INSTRUCTION  in  32  raw instruction word.
- IMM_PICK  in  3  immediate format select.
- PC  in  XLEN  address of INSTRUCTION.
- FLUSH  in  1  discard all held entries.
- OUT_VALID  out  1  IMMIDIATE/TARGET/ILLEGAL_PICK are valid.
- OUT_READY  in  1  downstream accepts this cycle.
- IMMIDIATE  out  XLEN  extended immediate.
- TARGET  out  XLEN  PC + IMMIDIATE, modulo 2^XLEN.
- ILLEGAL_PICK  out  1  IMM_PICK code is unsupported; IMMIDIATE forced to 0.

## Operation
- IMM_PICK decode, with sign = INSTRUCTION[31] extended to XLEN:
  - 000 I: inst[31:20].
  - 001 S: {inst[31:25], inst[11:7]}.
  - 010 U: {inst[31:12], 12'b0}, sign-extended when XLEN=64.
  - 011 B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - 100 J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - 101 SHAMT: zero-extended; inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
  - 110 ZIMM: see Configuration.
  - 111: illegal.
- An illegal code gives IMMIDIATE = 0, TARGET = PC, and ILLEGAL_PICK = 1. The entry is still passed downstream.
- TARGET is computed for every code; downstream ignores it where it is not meaningful.
- Storage: a main output register and a skid register, each holding {valid, IMMIDIATE, TARGET, ILLEGAL_PICK}.
- Occupancy states:
  - EMPTY → ONE on accept.
  - ONE → TWO on accept with OUT_VALID & !OUT_READY.
  - ONE → EMPTY on drain without accept.
  - TWO → ONE when OUT_READY.
- A transfer occurs on a cycle where the corresponding valid and ready are both 1.
- IN_READY = !skid_valid. It is driven from a register, with no combinational path from OUT_READY.
- When the main register drains and the skid is full, the skid entry moves to main in the same edge.
- FLUSH has priority over everything. Both valids clear at the next edge, and an input offered in the same cycle is dropped.

## Timing
- Reset values (asynchronous, immediate on RESET_N low): OUT_VALID=0, IN_READY=1, IMMIDIATE=0, TARGET=0, ILLEGAL_PICK=0, skid empty.
- Latency: 1 cycle from accepted input to OUT_VALID with the result.
- Throughput: 1 per cycle while OUT_READY=1.
- While OUT_VALID=1 and OUT_READY=0, all outputs are held stable.
- Simultaneous accept and drain in state ONE: the main register reloads with the new entry and the state stays ONE.
- Reset asserted mid-operation: all entries are lost, with no partial output.
- Deasserting RESET_N is synchronised externally, so the first accept can occur at the first edge after release.

## Configuration
- IMM_GEN_ZIMM_EN defined:
  - IMM_PICK 110 yields the CSR zimm, inst[19:15] zero-extended.
  - ILLEGAL_PICK=0 for this code.
- IMM_GEN_ZIMM_EN undefined:
  - 110 is treated as illegal: IMMIDIATE=0, ILLEGAL_PICK=1.
  - No zimm mux logic is synthesised.

## Test plan
- Reset check: hold RESET_N=0 mid-stream, then release. Required: OUT_VALID=0, IN_READY=1, outputs 0.
- Format sweep, XLEN=32, OUT_READY=1:
  - 0xFFF00000/000 → 0xFFFFFFFF.
  - 0xFE000F80/001 → 0xFFFFFFFF.
  - 0xFE000F80/011 → 0xFFFFFFFE.
  - 0x87654321/100 → 0xFFF54076.
  - 0x01F00000/101 → 0x0000001F.
  - Each result appears exactly one cycle after the accept.
- Target wrap: 0xFFFFF000/010 with PC=0x00001000 → IMMIDIATE=0xFFFFF000, TARGET=0x00000000.
- Backpressure: OUT_READY=0, push A then B.
  - IN_READY must drop after B.
  - A third input C is held upstream.
  - Raise OUT_READY: outputs must appear in order A, B, C with no loss or duplication.
- Flush: with two entries held, assert FLUSH together with IN_VALID. Required next cycle: OUT_VALID=0, IN_READY=1, and the new input is dropped.
- Config: IMM_PICK=110 with 0x000F8000.
  - With IMM_GEN_ZIMM_EN: 0x1F, ILLEGAL_PICK=0.
  - Without it: 0, ILLEGAL_PICK=1.
  - Code 111 gives ILLEGAL_PICK=1 in both builds.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered RV32IM/RV64 immediate generator with PC+imm target and a two-entry skid buffer.
// Optional CSR zimm decode for IMM_PICK=110 is enabled with `define IMM_GEN_ZIMM_EN.
module imm_gen_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   input  logic [2:0]      imm_pick,
   input  logic [XLEN-1:0] pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] immidiate,
   output logic [XLEN-1:0] target,
   output logic            illegal_pick
);

   // state | meaning
   // EMPTY | no entry held
   // ONE   | main register holds the output entry, skid empty
   // TWO   | main and skid both hold entries; upstream is stalled
   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

   occ_t            state, state_nxt;
   logic            accept, load_main, load_skid, main_from_skid;
   logic [63:0]     wide;
   logic [XLEN-1:0] new_imm, new_tgt;
   logic            new_ill;
   logic [XLEN-1:0] skid_imm, skid_tgt;
   logic            skid_ill;
   logic            s;

   assign s = instruction[31];

   // All formats are built at 64 bits and truncated, so one mux serves both XLEN values.
   always_comb begin
      wide    = '0;
      new_ill = 1'b0;
      case (imm_pick)
         3'b000: wide = {{52{s}}, instruction[31:20]};
         3'b001: wide = {{52{s}}, instruction[31:25], instruction[11:7]};
         3'b010: wide = {{32{s}}, instruction[31:12], 12'b0};
         3'b011: wide = {{51{s}}, instruction[31], instruction[7], instruction[30:25],
                         instruction[11:8], 1'b0};
         3'b100: wide = {{43{s}}, instruction[31], instruction[19:12], instruction[20],
                         instruction[30:21], 1'b0};
         3'b101: begin
            if (XLEN == 64) wide = {58'b0, instruction[25:20]};
            else            wide = {59'b0, instruction[24:20]};
         end
`ifdef IMM_GEN_ZIMM_EN
         3'b110: wide = {59'b0, instruction[19:15]};
`else
         3'b110: new_ill = 1'b1;
`endif
         default: new_ill = 1'b1;
      endcase
   end

   assign new_imm = wide[XLEN-1:0];
   assign new_tgt = pc + new_imm;

   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= EMPTY;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  load_main = 1'b1;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (accept && out_ready) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_nxt = TWO;
               end else if (out_ready) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (out_ready) begin
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
                  state_nxt      = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         immidiate    <= '0;
         target       <= '0;
         illegal_pick <= 1'b0;
         skid_imm     <= '0;
         skid_tgt     <= '0;
         skid_ill     <= 1'b0;
      end else begin
         if (load_main) begin
            immidiate    <= main_from_skid ? skid_imm : new_imm;
            target       <= main_from_skid ? skid_tgt : new_tgt;
            illegal_pick <= main_from_skid ? skid_ill : new_ill;
         end
         if (load_skid) begin
            skid_imm <= new_imm;
            skid_tgt <= new_tgt;
            skid_ill <= new_ill;
         end
      end
   end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomized and directed bench for imm_gen_stage (XLEN=32) against a queue-based reference model.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [2:0]  imm_pick;
   logic [31:0] pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] immidiate;
   logic [31:0] target;
   logic        illegal_pick;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic [31:0] imm;
      logic [31:0] tgt;
      logic        ill;
   } entry_t;

   entry_t q[$];

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(32)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .instruction  (instruction),
      .imm_pick     (imm_pick),
      .pc           (pc),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .immidiate    (immidiate),
      .target       (target),
      .illegal_pick (illegal_pick)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference decode written from the format rules as integer arithmetic.
   function automatic entry_t model(input logic [31:0] inst, input logic [2:0] pick,
                                    input logic [31:0] pcv);
      entry_t e;
      logic [31:0] v;
      logic [31:0] neg;
      e.ill = 1'b0;
      neg = inst[31] ? 32'hFFFF_FFFF : 32'h0;
      case (pick)
         3'd0: v = 32'($signed(inst) >>> 20);
         3'd1: v = (32'($signed(inst) >>> 25) << 5) | ((inst >> 7) & 32'd31);
         3'd2: v = inst & 32'hFFFF_F000;
         3'd3: v = (neg << 12) + (((inst >> 7) & 32'd1) << 11)
                   + (((inst >> 25) & 32'd63) << 5) + (((inst >> 8) & 32'd15) << 1);
         3'd4: v = (neg << 20) + (((inst >> 12) & 32'd255) << 12)
                   + (((inst >> 20) & 32'd1) << 11) + (((inst >> 21) & 32'd1023) << 1);
         3'd5: v = (inst >> 20) & 32'd31;
`ifdef IMM_GEN_ZIMM_EN
         3'd6: v = (inst >> 15) & 32'd31;
`endif
         default: begin
            v = 32'd0;
            e.ill = 1'b1;
         end
      endcase
      e.imm = v;
      e.tgt = pcv + v;
      return e;
   endfunction

   // Called just after a falling edge: drive inputs, check outputs, advance the model over one rising edge.
   task automatic step(input logic iv, input logic [31:0] ins, input logic [2:0] pk,
                       input logic [31:0] pcv, input logic fl, input logic ordy);
      int sz;
      in_valid = iv; instruction = ins; imm_pick = pk; pc = pcv; flush = fl; out_ready = ordy;
      #1;
      sz = q.size();
      check("out_valid", 64'(out_valid), 64'(sz > 0));
      check("in_ready", 64'(in_ready), 64'(sz < 2));
      if (sz > 0) begin
         check("immidiate", 64'(immidiate), 64'(q[0].imm));
         check("target", 64'(target), 64'(q[0].tgt));
         check("illegal_pick", 64'(illegal_pick), 64'(q[0].ill));
      end
      if (fl) begin
         q.delete();
      end else begin
         if (ordy && sz > 0) void'(q.pop_front());
         if (iv && sz < 2) q.push_back(model(ins, pk, pcv));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, ordy);
   endtask

   // Push one instruction with OUT_READY=1 and check the spec's literal result one cycle later.
   task automatic directed(input string tag, input logic [31:0] ins, input logic [2:0] pk,
                           input logic [31:0] pcv, input logic [31:0] exp_imm,
                           input logic [31:0] exp_tgt, input logic exp_ill);
      step(1'b1, ins, pk, pcv, 1'b0, 1'b1);
      #1;
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_imm"}, 64'(immidiate), 64'(exp_imm));
      check({tag, "_tgt"}, 64'(target), 64'(exp_tgt));
      check({tag, "_ill"}, 64'(illegal_pick), 64'(exp_ill));
      idle(1'b1);
   endtask

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0; instruction = '0; imm_pick = '0; pc = '0; flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      directed("fmt_i", 32'hFFF0_0000, 3'd0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      directed("fmt_s", 32'hFE00_0F80, 3'd1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      directed("fmt_b", 32'hFE00_0F80, 3'd3, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0);
      directed("fmt_j", 32'h8765_4321, 3'd4, 32'h0, 32'hFFF5_4076, 32'hFFF5_4076, 1'b0);
      directed("fmt_sh", 32'h01F0_0000, 3'd5, 32'h0, 32'h0000_001F, 32'h0000_001F, 1'b0);
      directed("wrap_u", 32'hFFFF_F000, 3'd2, 32'h0000_1000, 32'hFFFF_F000, 32'h0, 1'b0);
`ifdef IMM_GEN_ZIMM_EN
      directed("zimm", 32'h000F_8000, 3'd6, 32'h100, 32'h1F, 32'h11F, 1'b0);
`else
      directed("zimm", 32'h000F_8000, 3'd6, 32'h100, 32'h0, 32'h100, 1'b1);
`endif
      directed("ill7", 32'h000F_8000, 3'd7, 32'h200, 32'h0, 32'h200, 1'b1);

      // Backpressure: A, B accepted, C held upstream until the stall clears.
      step(1'b1, 32'h0010_0000, 3'd0, 32'h10, 1'b0, 1'b0);
      step(1'b1, 32'h0020_0000, 3'd0, 32'h20, 1'b0, 1'b0);
      #1 check("bp_in_ready_low", 64'(in_ready), 64'd0);
      step(1'b1, 32'h0030_0000, 3'd0, 32'h30, 1'b0, 1'b0);
      step(1'b1, 32'h0030_0000, 3'd0, 32'h30, 1'b0, 1'b0);
      #1 check("bp_hold_a", 64'(immidiate), 64'h1);
      step(1'b1, 32'h0030_0000, 3'd0, 32'h30, 1'b0, 1'b1);
      step(1'b1, 32'h0030_0000, 3'd0, 32'h30, 1'b0, 1'b1);
      step(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1);
      idle(1'b1);
      check("bp_drained", 64'(q.size()), 64'd0);

      // Flush with two entries held and a simultaneous offer.
      step(1'b1, 32'h0040_0000, 3'd0, 32'h40, 1'b0, 1'b0);
      step(1'b1, 32'h0050_0000, 3'd0, 32'h50, 1'b0, 1'b0);
      step(1'b1, 32'h0060_0000, 3'd0, 32'h60, 1'b1, 1'b0);
      #1;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      idle(1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) != 0));
      end

      // Reset mid-stream: entries lost, outputs zero immediately.
      step(1'b1, 32'hFFF0_0000, 3'd0, 32'h1234, 1'b0, 1'b0);
      step(1'b1, 32'hFFF0_0000, 3'd1, 32'h1234, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_imm", 64'(immidiate), 64'd0);
      check("rst_tgt", 64'(target), 64'd0);
      check("rst_ill", 64'(illegal_pick), 64'd0);
      q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      directed("post_rst", 32'hFFF0_0000, 3'd0, 32'h10, 32'hFFFF_FFFF, 32'h0F, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
